// File: rtl/pcileech_bar_rsp_arbiter.sv
// Merges BAR read responses from NSRC sources into one registered valid/ready stream.
// Define BAR_RSP_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module pcileech_bar_rsp_arbiter #(
  parameter int NSRC  = 3,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*88-1:0]   src_rsp_ctx,
  input  logic [NSRC*32-1:0]   src_rsp_data,
  input  logic [NSRC-1:0]      src_rsp_valid,
  output logic [87:0]          rsp_ctx,
  output logic [31:0]          rsp_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NSRC-1:0]      src_ovf,
  output logic                 busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int EW = 120;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [EW-1:0]   mem    [NSRC][DEPTH];
  logic [AW-1:0]   wr_ptr [NSRC];
  logic [AW-1:0]   rd_ptr [NSRC];
  logic [AW:0]     cnt    [NSRC];
  logic [NSRC-1:0] nonempty;
  logic [NSRC-1:0] full;
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic            load;
  logic            grant_vld;
  logic [GW-1:0]   grant;
  logic [EW-1:0]   head_p0;

  assign load = !rsp_valid || rsp_ready;
  assign busy = (|nonempty) || rsp_valid;

  // A full FIFO still accepts a strobe when its head leaves in the same cycle.
  always_comb begin
    nonempty = '0;
    full     = '0;
    pop      = '0;
    push     = '0;
    for (int i = 0; i < NSRC; i++) begin
      nonempty[i] = (cnt[i] != '0);
      full[i]     = (cnt[i] == FULL_CNT);
      pop[i]      = load && grant_vld && (grant == GW'(i));
      push[i]     = src_rsp_valid[i] && (!full[i] || pop[i]);
    end
  end

`ifdef BAR_RSP_ARB_RR_EN
  logic [GW-1:0] rr_ptr;
  int            idx;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int k = 0; k < NSRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!grant_vld && nonempty[idx[GW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = idx[GW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (load && grant_vld) begin
      rr_ptr <= (grant == GW'(NSRC-1)) ? '0 : grant + 1'b1;
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = NSRC-1; k >= 0; k--) begin
      if (nonempty[k]) begin
        grant_vld = 1'b1;
        grant     = GW'(k);
      end
    end
  end
`endif

  // FIFO storage carries no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {src_rsp_ctx[88*i +: 88], src_rsp_data[32*i +: 32]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      src_ovf <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
        if (src_rsp_valid[i] && !push[i]) src_ovf[i] <= 1'b1;
      end
    end
  end

  always_comb head_p0 = mem[grant][rd_ptr[grant]];

  // Output stage: holds while stalled, reloads or empties whenever load is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_ctx   <= '0;
      rsp_data  <= '0;
    end else if (load) begin
      rsp_valid <= grant_vld;
      if (grant_vld) {rsp_ctx, rsp_data} <= head_p0;
    end
  end

endmodule
